// File: rtl/axis_sink_cfg_sequencer_if.sv
// AXI4-Lite bundle between the configuration sequencer (master) and the
// sink's S00_AXI register slave.
interface axis_sink_cfg_sequencer_if;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARPROT, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARPROT, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axis_sink_cfg_sequencer.sv
// AXI4-Lite master that writes a register table into the sink's S00_AXI bank,
// reads every word back and reports pass/fail with the first failing index.
module axis_sink_cfg_sequencer #(
    parameter int unsigned NUM_REGS  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      start,
    input  logic [32*NUM_REGS-1:0]    cfg_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [3:0]                err_index,
    output logic [1:0]                err_code,
    axis_sink_cfg_sequencer_if.master m_axi
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    localparam logic [1:0] ErrOk       = 2'd0;
    localparam logic [1:0] ErrResp     = 2'd1;
    localparam logic [1:0] ErrMismatch = 2'd2;
    localparam logic [1:0] ErrTimeout  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWresp,
        StRd,
        StRdata,
        StCheck,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     index_q, index_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           bready_q, bready_d;
    logic           arvalid_q, arvalid_d;
    logic           rready_q, rready_d;
    logic [31:0]    awaddr_q, awaddr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    araddr_q, araddr_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic [3:0]     err_index_q, err_index_d;
    logic [1:0]     err_code_q, err_code_d;

    logic           aw_ok, w_ok, waiting, fail;
    logic [1:0]     fail_code;
    logic [3:0]     next_index;

    function automatic logic [31:0] reg_addr(input logic [3:0] idx);
        return BASE_ADDR + {26'd0, idx, 2'b00};
    endfunction

    // Constant-index mux keeps the table lookup in range for any NUM_REGS.
    function automatic logic [31:0] word_at(input logic [32*NUM_REGS-1:0] tbl,
                                            input logic [3:0] idx);
        logic [31:0] w;
        w = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) w = tbl[32*i +: 32];
        end
        return w;
    endfunction

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        araddr_d    = araddr_q;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_index_d = err_index_q;
        err_code_d  = err_code_q;
        fail        = 1'b0;
        fail_code   = ErrOk;
        next_index  = index_q + 4'd1;

        // A write channel is finished once its VALID has dropped or is handshaking now.
        aw_ok   = !awvalid_q || m_axi.AWREADY;
        w_ok    = !wvalid_q || m_axi.WREADY;
        waiting = (state_q == StWr) || (state_q == StWresp) ||
                  (state_q == StRd) || (state_q == StRdata);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StWr;
                    index_d     = 4'd0;
                    pass_d      = 1'b0;
                    err_code_d  = ErrOk;
                    err_index_d = 4'd0;
                    busy_d      = 1'b1;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    awaddr_d    = reg_addr(4'd0);
                    wdata_d     = word_at(cfg_data, 4'd0);
                end
            end
            StWr: begin
                if (awvalid_q && m_axi.AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.WREADY) wvalid_d = 1'b0;
                if (aw_ok && w_ok) begin
                    state_d  = StWresp;
                    bready_d = 1'b1;
                end
            end
            StWresp: begin
                if (m_axi.BVALID) begin
                    bready_d = 1'b0;
                    if (m_axi.BRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = ErrResp;
                    end else begin
                        state_d   = StRd;
                        arvalid_d = 1'b1;
                        araddr_d  = awaddr_q;
                    end
                end
            end
            StRd: begin
                if (m_axi.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (m_axi.RVALID) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axi.RDATA;
                    if (m_axi.RRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = ErrResp;
                    end else begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (rdata_q != word_at(cfg_data, index_q)) begin
                    fail      = 1'b1;
                    fail_code = ErrMismatch;
                end else if (index_q == 4'(NUM_REGS - 1)) begin
                    state_d = StDone;
                    pass_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d   = StWr;
                    index_d   = next_index;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = reg_addr(next_index);
                    wdata_d   = word_at(cfg_data, next_index);
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout abandons whatever transaction is outstanding.
        if (waiting && tcnt_q == TW'(TIMEOUT - 1)) begin
            fail      = 1'b1;
            fail_code = ErrTimeout;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
        end

        if (fail) begin
            state_d     = StDone;
            err_code_d  = fail_code;
            err_index_d = index_q;
            pass_d      = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
        end

        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (waiting) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = '0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= StIdle;
            index_q     <= 4'd0;
            tcnt_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= 32'd0;
            wdata_q     <= 32'd0;
            araddr_q    <= 32'd0;
            rdata_q     <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_index_q <= 4'd0;
            err_code_q  <= ErrOk;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            tcnt_q      <= tcnt_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_index_q <= err_index_d;
            err_code_q  <= err_code_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_index = err_index_q;
    assign err_code  = err_code_q;

    assign m_axi.AWADDR  = awaddr_q;
    assign m_axi.AWPROT  = 3'b000;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = 4'hF;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARADDR  = araddr_q;
    assign m_axi.ARPROT  = 3'b000;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axis_sink_cfg_sequencer.sv
// Directed bench for axis_sink_cfg_sequencer against a small AXI4-Lite register
// slave with per-register wait states and fault injection.
module tb_axis_sink_cfg_sequencer;

    localparam int unsigned NREGS = 4;

    logic               tb_ACLK = 1'b0;
    logic               tb_ARESET;
    logic               start;
    logic [32*NREGS-1:0] cfg_data;
    logic               busy, done, pass;
    logic [3:0]         err_index;
    logic [1:0]         err_code;

    int checks   = 0;
    int failures = 0;

    axis_sink_cfg_sequencer_if bus ();

    axis_sink_cfg_sequencer #(
        .NUM_REGS  (NREGS),
        .BASE_ADDR (32'h0000_0000),
        .TIMEOUT   (16)
    ) dut (
        .ACLK      (tb_ACLK),
        .ARESET    (tb_ARESET),
        .start     (start),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_index (err_index),
        .err_code  (err_code),
        .m_axi     (bus)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    // Slave model configuration, written only by the stimulus block.
    int   aw_dly [16];
    int   w_dly [16];
    int   bresp_bad_idx;
    int   rdata_bad_idx;
    logic ar_block;

    int          aw_cnt, w_cnt;
    logic        have_aw, have_w;
    logic [31:0] aw_addr_l, w_data_l;
    logic        bvalid_r, rvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] rdata_r;
    logic [31:0] mem [16];
    int          writes = 0;
    int          reads = 0;
    int          attr_bad = 0;
    int          viol = 0;

    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [31:0] wr_addr, wr_data;

    assign bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_dly[bus.AWADDR[5:2]]);
    assign bus.WREADY  = bus.WVALID && (w_cnt >= w_dly[bus.AWADDR[5:2]]);
    assign bus.ARREADY = bus.ARVALID && !ar_block;
    assign bus.BVALID  = bvalid_r;
    assign bus.BRESP   = bresp_r;
    assign bus.RVALID  = rvalid_r;
    assign bus.RDATA   = rdata_r;
    assign bus.RRESP   = 2'b00;

    assign aw_hs   = bus.AWVALID && bus.AWREADY;
    assign w_hs    = bus.WVALID && bus.WREADY;
    assign ar_hs   = bus.ARVALID && bus.ARREADY;
    assign wr_fire = (have_aw || aw_hs) && (have_w || w_hs);
    assign wr_addr = have_aw ? aw_addr_l : bus.AWADDR;
    assign wr_data = have_w ? w_data_l : bus.WDATA;

    always @(posedge tb_ACLK or posedge tb_ARESET) begin
        if (tb_ARESET) begin
            aw_cnt   <= 0;
            w_cnt    <= 0;
            have_aw  <= 1'b0;
            have_w   <= 1'b0;
            bvalid_r <= 1'b0;
            bresp_r  <= 2'b00;
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
        end else begin
            aw_cnt <= (bus.AWVALID && !bus.AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.WVALID && !bus.WREADY) ? w_cnt + 1 : 0;
            if (aw_hs) begin
                have_aw   <= 1'b1;
                aw_addr_l <= bus.AWADDR;
            end
            if (w_hs) begin
                have_w   <= 1'b1;
                w_data_l <= bus.WDATA;
            end
            if ((aw_hs && bus.AWPROT != 3'b000) || (w_hs && bus.WSTRB != 4'hF) ||
                (ar_hs && bus.ARPROT != 3'b000)) begin
                attr_bad <= attr_bad + 1;
            end
            if (bvalid_r && bus.BREADY) bvalid_r <= 1'b0;
            if (wr_fire) begin
                mem[wr_addr[5:2]] <= wr_data;
                writes   <= writes + 1;
                have_aw  <= 1'b0;
                have_w   <= 1'b0;
                bvalid_r <= 1'b1;
                bresp_r  <= (int'(wr_addr[5:2]) == bresp_bad_idx) ? 2'b10 : 2'b00;
            end
            if (rvalid_r && bus.RREADY) rvalid_r <= 1'b0;
            if (ar_hs) begin
                rvalid_r <= 1'b1;
                reads    <= reads + 1;
                rdata_r  <= (int'(bus.ARADDR[5:2]) == rdata_bad_idx) ? 32'd0
                                                                      : mem[bus.ARADDR[5:2]];
            end
        end
    end

    // VALID must hold with stable payload until its handshake and drop right after it.
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awa, p_wd, p_ara;

    always @(negedge tb_ACLK) begin
        if (tb_ARESET || done) begin
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0;
            p_wr  <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
        end else begin
            if ((p_awv && !p_awr && (!bus.AWVALID || bus.AWADDR != p_awa)) ||
                (p_wv && !p_wr && (!bus.WVALID || bus.WDATA != p_wd)) ||
                (p_arv && !p_arr && (!bus.ARVALID || bus.ARADDR != p_ara)) ||
                (p_awv && p_awr && bus.AWVALID) || (p_wv && p_wr && bus.WVALID) ||
                (p_arv && p_arr && bus.ARVALID)) begin
                viol <= viol + 1;
            end
            p_awv <= bus.AWVALID; p_awr <= bus.AWREADY; p_awa <= bus.AWADDR;
            p_wv  <= bus.WVALID;  p_wr  <= bus.WREADY;  p_wd  <= bus.WDATA;
            p_arv <= bus.ARVALID; p_arr <= bus.ARREADY; p_ara <= bus.ARADDR;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            aw_dly[i] = 0;
            w_dly[i]  = 0;
        end
        bresp_bad_idx = -1;
        rdata_bad_idx = -1;
        ar_block      = 1'b0;
    endtask

    // Pulses start and counts clock edges (start edge = 1) until done is seen.
    task automatic run_seq(input int extra_at, output int cyc, output logic busy1);
        @(negedge tb_ACLK);
        start = 1'b1;
        @(posedge tb_ACLK);
        #1 start = 1'b0;
        cyc   = 1;
        busy1 = busy;
        while (done !== 1'b1 && cyc < 200) begin
            if (cyc == extra_at) start = 1'b1;
            @(posedge tb_ACLK);
            #1 start = 1'b0;
            cyc++;
        end
        check("done_seen", 32'(cyc < 200), 32'd1);
    endtask

    int   cyc, w0, r0, n;
    logic busy1;

    initial begin
        tb_ARESET = 1'b1;
        start     = 1'b0;
        cfg_data  = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};
        clear_cfg();

        // Reset state
        repeat (3) @(posedge tb_ACLK);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);
        check("rst_valids", 32'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 32'd0);
        check("rst_readys", 32'({bus.BREADY, bus.RREADY}), 32'd0);
        check("rst_awaddr", bus.AWADDR, 32'd0);
        check("rst_wdata", bus.WDATA, 32'd0);
        @(negedge tb_ACLK);
        tb_ARESET = 1'b0;

        // Zero-wait slave, with a stray start while busy that must be ignored
        w0 = writes; r0 = reads;
        run_seq(8, cyc, busy1);
        check("t1_busy_after_start", 32'(busy1), 32'd1);
        check("t1_cycles", 32'(cyc), 32'd21);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err_code", 32'(err_code), 32'd0);
        check("t1_err_index", 32'(err_index), 32'd0);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        check("t1_mem0", mem[0], 32'h0101FFFF);
        check("t1_mem1", mem[1], 32'habcd0001);
        check("t1_mem2", mem[2], 32'hdead0011);
        check("t1_mem3", mem[3], 32'hbeef0011);
        check("t1_writes", 32'(writes - w0), 32'd4);
        check("t1_reads", 32'(reads - r0), 32'd4);
        @(posedge tb_ACLK);
        #1;
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_pass_hold", 32'(pass), 32'd1);

        // AWREADY late on reg 0, WREADY late on reg 1
        clear_cfg();
        aw_dly[0] = 3;
        w_dly[1]  = 3;
        cfg_data  = {32'h0000_0004, 32'h0000_0003, 32'h1234_5678, 32'hCAFE_F00D};
        w0 = writes; r0 = reads;
        run_seq(-1, cyc, busy1);
        check("t2_cycles", 32'(cyc), 32'd27);
        check("t2_pass", 32'(pass), 32'd1);
        check("t2_writes", 32'(writes - w0), 32'd4);
        check("t2_mem0", mem[0], 32'hCAFE_F00D);
        check("t2_mem1", mem[1], 32'h1234_5678);
        check("t2_valid_rules", 32'(viol), 32'd0);

        // Read-back of reg 2 corrupted
        clear_cfg();
        rdata_bad_idx = 2;
        cfg_data = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF};
        w0 = writes; r0 = reads;
        run_seq(-1, cyc, busy1);
        check("t3_cycles", 32'(cyc), 32'd16);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_err_code", 32'(err_code), 32'd2);
        check("t3_err_index", 32'(err_index), 32'd2);
        repeat (4) @(posedge tb_ACLK);
        #1;
        check("t3_writes", 32'(writes - w0), 32'd3);
        check("t3_reads", 32'(reads - r0), 32'd3);
        check("t3_hold_code", 32'(err_code), 32'd2);

        // SLVERR on the write of reg 1
        clear_cfg();
        bresp_bad_idx = 1;
        w0 = writes; r0 = reads;
        run_seq(-1, cyc, busy1);
        check("t4_cycles", 32'(cyc), 32'd8);
        check("t4_err_code", 32'(err_code), 32'd1);
        check("t4_err_index", 32'(err_index), 32'd1);
        check("t4_pass", 32'(pass), 32'd0);
        repeat (3) @(posedge tb_ACLK);
        #1;
        check("t4_writes", 32'(writes - w0), 32'd2);
        check("t4_reads", 32'(reads - r0), 32'd1);

        // ARREADY stuck low: timeout 16 cycles after RD entry
        clear_cfg();
        ar_block = 1'b1;
        w0 = writes; r0 = reads;
        run_seq(-1, cyc, busy1);
        check("t5_cycles", 32'(cyc), 32'd19);
        check("t5_err_code", 32'(err_code), 32'd3);
        check("t5_err_index", 32'(err_index), 32'd0);
        check("t5_arvalid", 32'(bus.ARVALID), 32'd0);
        check("t5_reads", 32'(reads - r0), 32'd0);
        check("t5_valid_rules", 32'(viol), 32'd0);

        // Reset while WVALID is pending on reg 1, then a clean rerun
        clear_cfg();
        w_dly[1] = 6;
        @(negedge tb_ACLK);
        start = 1'b1;
        @(posedge tb_ACLK);
        #1 start = 1'b0;
        n = 0;
        while (!(bus.WVALID === 1'b1 && bus.AWADDR === 32'h4) && n < 100) begin
            @(posedge tb_ACLK);
            #1;
            n++;
        end
        check("t6_reached_reg1", 32'(n < 100), 32'd1);
        #1 tb_ARESET = 1'b1;
        #1;
        check("t6_rst_valids", 32'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 32'd0);
        check("t6_rst_readys", 32'({bus.BREADY, bus.RREADY}), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_awaddr", bus.AWADDR, 32'd0);
        check("t6_rst_wdata", bus.WDATA, 32'd0);
        check("t6_rst_err", 32'({pass, err_code, err_index}), 32'd0);
        @(posedge tb_ACLK);
        #2 tb_ARESET = 1'b0;
        clear_cfg();
        cfg_data = {32'h0000_00D4, 32'h0000_00C3, 32'h0000_00B2, 32'h0000_00A1};
        w0 = writes; r0 = reads;
        run_seq(-1, cyc, busy1);
        check("t6_cycles", 32'(cyc), 32'd21);
        check("t6_pass", 32'(pass), 32'd1);
        check("t6_writes", 32'(writes - w0), 32'd4);
        check("t6_mem0", mem[0], 32'h0000_00A1);
        check("t6_mem3", mem[3], 32'h0000_00D4);
        check("t6_attrs", 32'(attr_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_sink_cfg_sequencer.md
Name: axis_sink_cfg_sequencer

Overview:
- AXI4-Lite master that configures the AXI4-Stream data sink's S00_AXI register bank after reset.
- Writes a table of NUM_REGS words to consecutive word addresses, reads each back, compares, and reports pass/fail plus the failing index.
- Sits between system bring-up logic (start pulse) and the sink's S00_AXI slave port. Replaces bench-only bus-functional-model sequencing in hardware builds.

Parameters:
- NUM_REGS, 4, number of registers written and verified (1..16).
- BASE_ADDR, 32'h0000_0000, address of register 0; register i is at BASE_ADDR + 4*i.
- TIMEOUT, 256, maximum cycles spent waiting in any single handshake phase before abort (>=2).

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; ignored unless in IDLE or DONE.
- cfg_data  in  32*NUM_REGS  register table; word i is cfg_data[32*i+31:32*i], sampled per transfer.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- pass  out  1  sticky result, valid when busy is low after done.
- err_index  out  4  index of the first failing register; 0 on pass.
- err_code  out  2  0=ok, 1=bad BRESP/RRESP, 2=data mismatch, 3=timeout.
- M_AXI_AWADDR/AWPROT/AWVALID  out  32/3/1  write address channel; AWPROT is always 0.
- M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  write data channel; WSTRB is always 4'hF.
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR/ARPROT/ARVALID  out  32/3/1  read address channel; ARPROT is always 0.
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset values: all VALID/READY outputs 0, busy=0, done=0, pass=0, err_index=0, err_code=0, addresses and WDATA 0, index counter 0, timeout counter 0.
- FSM states: IDLE, WR, WRESP, RD, RDATA, CHECK, DONE.
- IDLE/DONE + start: index <= 0, pass <= 0, err_code <= 0, next state WR.
- WR: AWVALID and WVALID are asserted together in the first WR cycle, with AWADDR = BASE_ADDR + 4*index and WDATA = word[index].
  - Each VALID drops independently on its own handshake (VALID & READY).
  - Leave WR once both handshakes have completed; same-cycle and either-order completion are both legal.
- WRESP: BREADY=1.
  - On BVALID: BRESP != 2'b00 -> DONE with err_code=1.
  - Otherwise -> RD.
- RD: ARVALID=1 with ARADDR equal to the write address; on ARREADY -> RDATA.
- RDATA: RREADY=1.
  - On RVALID: capture RDATA.
  - RRESP != 0 -> DONE with err_code=1.
  - Otherwise -> CHECK.
- CHECK (one cycle): compare captured data with word[index].
  - Mismatch -> DONE with err_code=2.
  - Match and index == NUM_REGS-1 -> DONE with pass=1.
  - Match otherwise -> index+1, WR.
- Timeout: counter clears on every state change and increments in WR/WRESP/RD/RDATA.
  - Reaching TIMEOUT-1 forces DONE with err_code=3.
  - All VALID/READY outputs deassert the same cycle; an outstanding AXI transaction is abandoned.
- Error latch: err_index latches index on any failure.
- VALID stability: a VALID, once asserted, holds with stable payload until its handshake or timeout. VALID never depends combinationally on READY.
- DONE: done pulses for exactly one cycle on entry; busy=0; pass, err_code and err_index hold until the next start.
- Start while busy: ignored.
- ARESET mid-transaction: immediate return to reset values. No recovery of the slave side is attempted.
- Minimum per-register latency with zero-wait slave: WR 1, WRESP 1, RD 1, RDATA 1, CHECK 1 = 5 cycles. Full table = 5*NUM_REGS cycles from start to done, plus 1 for the DONE entry.

Test Plan:
- Zero-wait slave model, table {0101FFFF, abcd0001, dead0011, beef0011}, BASE_ADDR=0 -> writes land at 0x0/0x4/0x8/0xC, readbacks match, done after 21 cycles, pass=1, err_code=0.
- AWREADY delayed 3 cycles and WREADY immediate, then reversed on the next register -> each VALID drops only on its own handshake, one write per register, pass=1.
- Slave returns RDATA=0x0 for register 2 -> done, pass=0, err_code=2, err_index=2, no AXI activity for register 3.
- BRESP=2'b10 on register 1 -> err_code=1, err_index=1, no read issued for register 1.
- ARREADY held low, TIMEOUT=16 -> DONE 16 cycles after RD entry, ARVALID drops, err_code=3, err_index=0.
- ARESET pulsed while WVALID=1 on register 1 -> all outputs return to reset values within the reset cycle; a new start reruns the table from index 0 and passes.
